// File: rtl/tpu_ctrl_pkg.sv
// Shared types and constants for the TPU tile scheduler.
package tpu_ctrl_pkg;

  localparam int unsigned ARRAY_SIZE = 4;
  localparam int unsigned DRAIN_CYC  = 2 * ARRAY_SIZE - 1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StDrain,
    StWrite,
    StDone
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned x);
    return (x + ARRAY_SIZE - 1) / ARRAY_SIZE;
  endfunction

endpackage

// File: rtl/tpu_tile_iter.sv
// Nested row-tile / column-tile counters; column tile is the inner loop.
module tpu_tile_iter #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            adv_i,
  input  logic [CntW-1:0] rt_max_i,
  input  logic [CntW-1:0] ct_max_i,
  output logic [CntW-1:0] rt_o,
  output logic [CntW-1:0] ct_o,
  output logic            last_tile_o
);

  logic [CntW-1:0] rt_q, rt_d, ct_q, ct_d;
  logic            ct_wrap;

  assign ct_wrap     = (ct_q == ct_max_i);
  assign last_tile_o = ct_wrap && (rt_q == rt_max_i);
  assign rt_o        = rt_q;
  assign ct_o        = ct_q;

  always_comb begin
    rt_d = rt_q;
    ct_d = ct_q;
    if (clr_i) begin
      rt_d = '0;
      ct_d = '0;
    end else if (adv_i) begin
      if (ct_wrap) begin
        ct_d = '0;
        rt_d = last_tile_o ? '0 : rt_q + CntW'(1);
      end else begin
        ct_d = ct_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rt_q <= '0;
      ct_q <= '0;
    end else begin
      rt_q <= rt_d;
      ct_q <= ct_d;
    end
  end

endmodule

// File: rtl/tpu_tile_ctrl.sv
// Tile scheduler sequencing the systolic array over an MxK by KxN product.
// Optional cycle counter port enabled by defining TPU_CTRL_PERF_EN.
module tpu_tile_ctrl
  import tpu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DIM_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  m,
  input  logic [DIM_W-1:0]  k,
  input  logic [DIM_W-1:0]  n,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] b_addr,
  output logic              pe_clear,
  output logic              pe_shift,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_addr,
  output logic [1:0]        out_row_sel,
  output logic              busy,
  output logic              done
`ifdef TPU_CTRL_PERF_EN
  ,
  output logic [15:0]       cycle_cnt
`endif
);

  localparam int unsigned DcW = $clog2(DRAIN_CYC);

  state_e           state_q, state_d;
  logic [DIM_W-1:0] m_q, m_d, k_q, k_d, n_q, n_d;
  logic [DIM_W-1:0] kk_q, kk_d;
  logic [DcW-1:0]   dc_q, dc_d;
  logic [1:0]       r_q, r_d;
  logic [1:0]       r_last;
  logic             iter_clr, iter_adv, last_tile;
  logic [DIM_W-1:0] rt, ct, rt_max, ct_max, ceil_n;

  assign ceil_n = DIM_W'(ceil_div(32'(n_q)));
  assign rt_max = DIM_W'(ceil_div(32'(m_q)) - 1);
  assign ct_max = ceil_n - DIM_W'(1);
  // Only the final row tile can be partial; its row count is ((m-1) mod 4) + 1.
  assign r_last = (rt == rt_max) ? 2'(m_q - DIM_W'(1)) : 2'(ARRAY_SIZE - 1);

  tpu_tile_iter #(
    .CntW(DIM_W)
  ) u_iter (
    .clk_i      (clk),
    .rst_ni     (rst),
    .clr_i      (iter_clr),
    .adv_i      (iter_adv),
    .rt_max_i   (rt_max),
    .ct_max_i   (ct_max),
    .rt_o       (rt),
    .ct_o       (ct),
    .last_tile_o(last_tile)
  );

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    k_d      = k_q;
    n_d      = n_q;
    kk_d     = kk_q;
    dc_d     = dc_q;
    r_d      = r_q;
    iter_clr = 1'b0;
    iter_adv = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          m_d      = m;
          k_d      = k;
          n_d      = n;
          kk_d     = '0;
          dc_d     = '0;
          r_d      = '0;
          iter_clr = 1'b1;
          state_d  = (m == '0 || k == '0 || n == '0) ? StDone : StClear;
        end
      end
      StClear: begin
        kk_d    = '0;
        state_d = StFeed;
      end
      StFeed: begin
        if (kk_q == k_q - DIM_W'(1)) begin
          kk_d    = '0;
          dc_d    = '0;
          state_d = StDrain;
        end else begin
          kk_d = kk_q + DIM_W'(1);
        end
      end
      StDrain: begin
        if (dc_q == DcW'(DRAIN_CYC - 1)) begin
          dc_d    = '0;
          r_d     = '0;
          state_d = StWrite;
        end else begin
          dc_d = dc_q + DcW'(1);
        end
      end
      StWrite: begin
        if (r_q == r_last) begin
          r_d      = '0;
          iter_adv = 1'b1;
          state_d  = last_tile ? StDone : StClear;
        end else begin
          r_d = r_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      m_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      kk_q    <= '0;
      dc_q    <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      k_q     <= k_d;
      n_q     <= n_d;
      kk_q    <= kk_d;
      dc_q    <= dc_d;
      r_q     <= r_d;
    end
  end

  // Outputs decode purely from registered state and counters.
  always_comb begin
    a_rd_en     = (state_q == StFeed);
    b_rd_en     = (state_q == StFeed);
    pe_clear    = (state_q == StClear);
    pe_shift    = (state_q == StFeed) || (state_q == StDrain);
    out_wr_en   = (state_q == StWrite);
    busy        = (state_q == StClear) || (state_q == StFeed) ||
                  (state_q == StDrain) || (state_q == StWrite);
    done        = (state_q == StDone);
    a_addr      = '0;
    b_addr      = '0;
    out_addr    = '0;
    out_row_sel = '0;
    if (a_rd_en) begin
      a_addr = ADDR_W'(rt) * ADDR_W'(k_q) + ADDR_W'(kk_q);
      b_addr = ADDR_W'(ct) * ADDR_W'(k_q) + ADDR_W'(kk_q);
    end
    if (out_wr_en) begin
      out_addr    = (ADDR_W'(rt) * ADDR_W'(ARRAY_SIZE) + ADDR_W'(r_q)) * ADDR_W'(ceil_n) +
                    ADDR_W'(ct);
      out_row_sel = r_q;
    end
  end

`ifdef TPU_CTRL_PERF_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (iter_clr) begin
      cyc_d = '0;
    end else if (busy && cyc_q != 16'hFFFF) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cycle_cnt = cyc_q;
`endif

endmodule
